// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone single-transfer initiator.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus watchdog: counts waiting cycles and flags when the last allowed one is reached.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and saturate at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator with a valid/ready request and
// response channel and a watchdog that aborts transfers to silent targets.
module wb_master_bridge
    import wb_master_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned SW            = DW / 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_adr_i,
    input  logic [DW-1:0] req_dat_i,
    input  logic [SW-1:0] req_sel_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_dat_o,
    output logic [1:0]    rsp_status_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [SW-1:0] wbm_sel_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i
);

    state_e        state_q;
    logic          req_ready_q;
    logic          cyc_q;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [SW-1:0] sel_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_dat_q;
    logic [1:0]    rsp_status_q;

    logic          accept_s;
    logic          wait_s;
    logic          expired_s;

    // A request is taken only while idle; the watchdog runs only on silent bus cycles.
    assign accept_s = (state_q == IDLE) && req_valid_i && req_ready_q;
    assign wait_s   = (state_q == BUS) && !wbm_ack_i && !wbm_err_i;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_n_i),
        .clear_i  (accept_s),
        .enable_i (wait_s),
        .expired_o(expired_s)
    );

    // Transfer FSM; every output is a register so the bus sees clean edges.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        we_q        <= req_we_i;
                        adr_q       <= req_adr_i;
                        dat_q       <= req_dat_i;
                        sel_q       <= req_sel_i;
                        cyc_q       <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= BUS;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                BUS: begin
                    // Target error beats ack; any target response beats the watchdog.
                    if (wbm_err_i) begin
                        rsp_status_q <= ST_ERR;
                        rsp_dat_q    <= '0;
                        cyc_q        <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else if (wbm_ack_i) begin
                        rsp_status_q <= ST_OK;
                        rsp_dat_q    <= we_q ? '0 : wbm_dat_i;
                        cyc_q        <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else if (expired_s) begin
                        rsp_status_q <= ST_TIMEOUT;
                        rsp_dat_q    <= '0;
                        cyc_q        <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cyc_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    cyc_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = cyc_q;
    assign wbm_we_o     = we_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized scoreboard bench for the Wishbone single-transfer initiator.
module tb_wb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int T  = 8;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_adr = '0;
    logic [DW-1:0] req_dat = '0;
    logic [SW-1:0] req_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic          cyc, stb, we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat = '0;
    logic          ack = 1'b0;
    logic          err = 1'b0;

    always #5 clk = ~clk;

    wb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_status_o(rsp_status),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat),
        .wbm_ack_i(ack), .wbm_err_i(err)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] dat;
        logic [1:0]    st;
    } rsp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            cycles;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    // slave plan for the current transfer
    int            pl_wait  = 0;
    int            pl_kind  = K_ACK;
    logic [DW-1:0] pl_rdata = '0;
    logic          stray_arm = 1'b0;
    logic          in_reset = 1'b1;
    int            hold_next = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wishbone target model driven on the falling edge
    int s_cnt = 0;
    always @(negedge clk) begin
        if (in_reset) begin
            ack = 1'b0; err = 1'b0; s_cnt = 0;
        end else if (cyc && stb) begin
            if (pl_kind != K_NONE && s_cnt == pl_wait) begin
                ack  = (pl_kind == K_ACK) || (pl_kind == K_BOTH);
                err  = (pl_kind == K_ERR) || (pl_kind == K_BOTH);
                rdat = pl_rdata;
            end else begin
                ack = 1'b0; err = 1'b0; rdat = $urandom;
            end
            s_cnt++;
        end else begin
            s_cnt = 0;
            rdat  = $urandom;
            if (stray_arm) begin
                ack = 1'b1; err = 1'($urandom); stray_arm = 1'b0;
            end else begin
                ack = 1'b0; err = 1'b0;
            end
        end
    end

    // Bus monitor: length of each cycle and stability of the driven fields
    bus_t b_cur;
    logic b_act = 1'b0;
    int   b_cnt = 0;
    logic b_stable = 1'b1;
    always @(negedge clk) begin
        if (in_reset) begin
            b_act = 1'b0;
        end else if (cyc) begin
            if (!b_act) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cyc: actual=cyc_high required=no_cycle");
                    b_cur.cycles = -1;
                end else begin
                    b_cur = bus_q.pop_front();
                end
                b_act = 1'b1; b_cnt = 0; b_stable = 1'b1;
            end
            b_cnt++;
            if (stb !== 1'b1 || we !== b_cur.we || adr !== b_cur.adr ||
                wdat !== b_cur.dat || sel !== b_cur.sel) b_stable = 1'b0;
        end else if (b_act) begin
            b_act = 1'b0;
            chk("bus_len", 64'(b_cnt), 64'(b_cur.cycles));
            chk("bus_fields_stable", 64'(b_stable), 64'd1);
        end
    end

    // Response monitor: pops the scoreboard, checks hold behaviour, drives rsp_ready
    logic          r_seen = 1'b0;
    logic          r_hold_ok = 1'b1;
    logic          prev_cyc = 1'b0;
    int            hold_left = 0;
    logic [DW-1:0] h_dat;
    logic [1:0]    h_st;
    rsp_t          r_exp;
    always @(negedge clk) begin
        if (in_reset) begin
            r_seen = 1'b0; rsp_ready = 1'b0; prev_cyc = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (!r_seen) begin
                    r_seen = 1'b1; r_hold_ok = 1'b1;
                    chk("rsp_latency", 64'(prev_cyc), 64'd1);
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp: actual=status %0d data %0h required=no_response", rsp_status, rsp_dat);
                    end else begin
                        r_exp = rsp_q.pop_front();
                        chk("rsp_dat", 64'(rsp_dat), 64'(r_exp.dat));
                        chk("rsp_status", 64'(rsp_status), 64'(r_exp.st));
                    end
                    h_dat = rsp_dat; h_st = rsp_status;
                    hold_left = hold_next; hold_next = 0;
                end else begin
                    if (rsp_dat !== h_dat || rsp_status !== h_st ||
                        req_ready !== 1'b0 || cyc !== 1'b0) r_hold_ok = 1'b0;
                end
                if (hold_left > 0) begin
                    rsp_ready = 1'b0; hold_left--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end else begin
                if (r_seen) chk("rsp_hold_stable", 64'(r_hold_ok), 64'd1);
                r_seen = 1'b0;
                rsp_ready = 1'($urandom_range(0, 1));
            end
            prev_cyc = cyc;
        end
    end

    // Reference: response and strobe length from the termination rules
    task automatic issue(input logic we_i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input int w, input int kind,
                         input logic [DW-1:0] rd, input logic stray);
        int   guard;
        rsp_t r;
        bus_t b;
        guard = 0;
        while (!req_ready && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_wait: actual=0 after %0d cycles required=1", guard);
            return;
        end
        if (kind == K_NONE || w > T - 1) begin
            r.st = 2'b10; r.dat = '0; b.cycles = T;
        end else begin
            b.cycles = w + 1;
            if (kind == K_ERR || kind == K_BOTH) begin
                r.st = 2'b01; r.dat = '0;
            end else begin
                r.st = 2'b00; r.dat = we_i ? 32'd0 : rd;
            end
        end
        b.we = we_i; b.adr = a; b.dat = d; b.sel = s;
        rsp_q.push_back(r);
        bus_q.push_back(b);
        pl_wait = w; pl_kind = kind; pl_rdata = rd;
        if (stray) stray_arm = 1'b1;
        req_valid = 1'b1; req_we = we_i; req_adr = a; req_dat = d; req_sel = s;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_adr = $urandom; req_dat = $urandom;
        req_sel = 4'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((rsp_q.size() != 0 || rsp_valid || cyc) && guard < 500) begin
            @(posedge clk); #1; guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", 64'(rsp_q.size() + bus_q.size()), 64'd0);
    endtask

    initial begin
        #12;
        chk("reset_cyc", 64'(cyc), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_reset = 1'b0;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_adr", 64'(adr), 64'd0);
        chk("reset_rsp_dat", 64'(rsp_dat), 64'd0);
        chk("reset_status", 64'(rsp_status), 64'd0);

        // zero-wait read
        issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, K_ACK, 32'hDEADBEEF, 1'b0);
        // write with three wait states
        issue(1'b1, 32'h3000_0010, 32'h1234_5678, 4'b0011, 3, K_ACK, 32'hFFFF_FFFF, 1'b0);
        // silent target, then a stray ack while the timeout response is held
        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, K_NONE, 32'hAAAA_5555, 1'b1);
        issue(1'b0, 32'h3000_0024, 32'h0, 4'hF, 1, K_ACK, 32'h0BAD_F00D, 1'b0);
        // ack and err together
        issue(1'b0, 32'h3000_0028, 32'h0, 4'hF, 2, K_BOTH, 32'h1111_2222, 1'b0);
        // responses on the expiry edge, and one cycle too late
        issue(1'b0, 32'h3000_002C, 32'h0, 4'hF, T - 1, K_ACK, 32'hCAFE_0001, 1'b0);
        issue(1'b1, 32'h3000_0030, 32'h5A5A_5A5A, 4'hC, T - 1, K_ERR, 32'h0, 1'b0);
        issue(1'b0, 32'h3000_0034, 32'h0, 4'hF, T, K_ACK, 32'hCAFE_0002, 1'b0);
        drain();
        // client stalls the response for five cycles
        hold_next = 5;
        issue(1'b0, 32'h3000_0038, 32'h0, 4'h3, 1, K_ACK, 32'h7777_8888, 1'b0);
        issue(1'b1, 32'h3000_003C, 32'h9999_0000, 4'h1, 0, K_ACK, 32'h0, 1'b0);
        drain();

        // asynchronous reset in the middle of a bus cycle
        issue(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, K_NONE, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midreset_cyc", 64'(cyc), 64'd0);
        chk("midreset_stb", 64'(stb), 64'd0);
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        rsp_q.delete();
        bus_q.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("postreset_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        in_reset = 1'b0;
        repeat (T + 4) @(posedge clk);
        #1;
        chk("postreset_no_rsp", 64'(rsp_valid), 64'd0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int k;
            int w;
            k = $urandom_range(0, 9);
            k = (k < 5) ? K_ACK : (k < 7) ? K_ERR : (k < 8) ? K_BOTH : K_NONE;
            w = $urandom_range(0, T + 2);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(1'($urandom), $urandom, $urandom, 4'($urandom), w, k, $urandom,
                  1'($urandom_range(0, 1)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
